// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer
//   Accepts 24-bit signed ADC conversions (one strobe per sample) and
//   optionally box-car averages blocks of 2^decim_log2 samples. Each result
//   is tagged with an 8-bit sequence number and queued in a first-word-
//   fall-through FIFO drained over a valid/ready stream.
//
//   Optional feature macro: ADC_SAMPLE_BUFFER_TSTAMP_EN
//     defined   : a free-running 32-bit cycle counter is captured at the
//                 first sample of each block and travels with the FIFO entry
//                 to out_tstamp.
//     undefined : out_tstamp is tied to 0; no counter or storage is built.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   sample_in     signed ADC sample
//   sample_valid  one-cycle strobe qualifying sample_in
//   enable        1 = accept samples, 0 = drop samples and partial block
//   decim_log2    averaging exponent (clamped to DECIM_MAX_LOG2)
//   out_data      {seq[7:0], average}, head of FIFO
//   out_tstamp    cycle count at first sample of head block
//   out_valid     FIFO non-empty
//   out_ready     consumer accept
//   level         FIFO occupancy 0..DEPTH
//   overflow      sticky: a result was dropped on a full FIFO
//   clear_ovf     one-cycle pulse clearing overflow (a same-cycle drop wins)
module adc_sample_buffer #(
  parameter int unsigned DATA_WIDTH     = 24,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned DECIM_MAX_LOG2 = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [DATA_WIDTH-1:0]                  sample_in,
  input  logic                                   sample_valid,
  input  logic                                   enable,
  input  logic [$clog2(DECIM_MAX_LOG2+1)-1:0]    decim_log2,
  output logic [DATA_WIDTH+8-1:0]                out_data,
  output logic [31:0]                            out_tstamp,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(DEPTH):0]                 level,
  output logic                                   overflow,
  input  logic                                   clear_ovf
);

  localparam int unsigned LOG2W  = $clog2(DECIM_MAX_LOG2 + 1);
  localparam int unsigned ACC_W  = DATA_WIDTH + DECIM_MAX_LOG2;
  localparam int unsigned CNT_W  = DECIM_MAX_LOG2 + 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned WORD_W = DATA_WIDTH + 8;

  // ---------------------------------------------------------------------
  // Decimation datapath
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [LOG2W-1:0]         shift_q;
  logic [7:0]               seq_q;

  logic                     accept_c;
  logic                     first_c;
  logic [LOG2W-1:0]         shift_req_c;
  logic [LOG2W-1:0]         shift_eff_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic [CNT_W-1:0]         cnt_inc_c;
  logic [CNT_W-1:0]         blk_len_c;
  logic                     done_c;
  logic [DATA_WIDTH-1:0]    result_c;
  logic [WORD_W-1:0]        wdata_c;

  // Block factor is taken live on the first sample of a block and held after.
  always_comb begin
    accept_c    = sample_valid && enable;
    first_c     = (cnt_q == '0);
    shift_req_c = (decim_log2 > LOG2W'(DECIM_MAX_LOG2)) ? LOG2W'(DECIM_MAX_LOG2)
                                                       : decim_log2;
    shift_eff_c = first_c ? shift_req_c : shift_q;
    sum_c       = acc_q + $signed({{DECIM_MAX_LOG2{sample_in[DATA_WIDTH-1]}}, sample_in});
    cnt_inc_c   = cnt_q + CNT_W'(1);
    blk_len_c   = CNT_W'(1) << shift_eff_c;
    done_c      = accept_c && (cnt_inc_c == blk_len_c);
    // Arithmetic shift floors toward minus infinity; the mean fits DATA_WIDTH.
    result_c    = DATA_WIDTH'(sum_c >>> shift_eff_c);
    wdata_c     = {seq_q, result_c};
  end

  // Accumulator, block counter, latched factor and sequence number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      seq_q   <= '0;
    end else if (!enable) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept_c) begin
      if (first_c) begin
        shift_q <= shift_req_c;
      end
      if (done_c) begin
        acc_q <= '0;
        cnt_q <= '0;
        seq_q <= seq_q + 8'd1;
      end else begin
        acc_q <= sum_c;
        cnt_q <= cnt_inc_c;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_q;
  logic [PTR_W:0]    rd_q;

  logic              full_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic [PTR_W:0]    wr_nxt_c;
  logic [PTR_W:0]    rd_nxt_c;
  logic              nonempty_nxt_c;
  logic              head_from_wr_c;

  always_comb begin
    full_c         = (level == (PTR_W+1)'(DEPTH));
    pop_c          = out_valid && out_ready;
    // A pop frees a slot on the same edge, so a full FIFO still accepts.
    push_c         = done_c && (!full_c || pop_c);
    drop_c         = done_c && full_c && !pop_c;
    wr_nxt_c       = wr_q + (PTR_W+1)'(push_c);
    rd_nxt_c       = rd_q + (PTR_W+1)'(pop_c);
    nonempty_nxt_c = (wr_nxt_c != rd_nxt_c);
    // Next head is the word being written when it lands in the head slot.
    head_from_wr_c = push_c && (wr_q[PTR_W-1:0] == rd_nxt_c[PTR_W-1:0]);
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_q[PTR_W-1:0]] <= wdata_c;
    end
  end

  // Pointers, registered head word, status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_q      <= wr_nxt_c;
      rd_q      <= rd_nxt_c;
      level     <= wr_nxt_c - rd_nxt_c;
      out_valid <= nonempty_nxt_c;
      // Head holds its last value once the FIFO runs empty.
      if (nonempty_nxt_c) begin
        out_data <= head_from_wr_c ? wdata_c : mem[rd_nxt_c[PTR_W-1:0]];
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional block timestamps
  // ---------------------------------------------------------------------
`ifdef ADC_SAMPLE_BUFFER_TSTAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] ts_q;
  logic [31:0] wts_c;
  logic [31:0] ts_mem [DEPTH];

  always_comb begin
    wts_c = first_c ? cyc_q : ts_q;
  end

  // Free-running cycle counter and first-sample capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (accept_c && first_c) begin
        ts_q <= cyc_q;
      end
    end
  end

  // Timestamp storage alongside the data array.
  always_ff @(posedge clk) begin
    if (push_c) begin
      ts_mem[wr_q[PTR_W-1:0]] <= wts_c;
    end
  end

  // Head timestamp, same timing as out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tstamp <= '0;
    end else if (nonempty_nxt_c) begin
      out_tstamp <= head_from_wr_c ? wts_c : ts_mem[rd_nxt_c[PTR_W-1:0]];
    end
  end
`else
  assign out_tstamp = 32'd0;
`endif

endmodule
